// File: rtl/receiver_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding and
// default frame/timing constants.
package receiver_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    localparam int lp_DATA_WIDTH            = 8;
    localparam int lp_BIT_COUNTER_WIDTH     = 3;
    localparam int lp_CLKS_PER_BIT          = 16;
    localparam int lp_CLK_COUNTER_WIDTH     = 4;

    // Counter value at the middle of the start bit and at the end of a bit.
    localparam int lp_HALF_BIT              = lp_CLKS_PER_BIT / 2 - 1;
    localparam int lp_FULL_BIT              = lp_CLKS_PER_BIT - 1;
    localparam int lp_DATA_WIDTH_minus_one  = lp_DATA_WIDTH - 1;

endpackage

// File: rtl/one_cycle_delayer.sv
// Single registered delay stage with a configurable reset value; chained to
// build the serial-line synchroniser.
module one_cycle_delayer #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic i_clock,
    input  logic i_resetL,
    input  logic i_d,
    output logic o_q
);

    // Register the input by one clock, loading the reset value on reset.
    always_ff @(posedge i_clock) begin
        if (!i_resetL) begin
            o_q <= RESET_VALUE;
        end else begin
            o_q <= i_d;
        end
    end

endmodule

// File: rtl/receiver_bit_counter.sv
// Data-bit index for the receiver: held at zero outside the DATA state,
// advanced on every mid-bit sample, flags the last data bit of the frame.
module receiver_bit_counter
    import receiver_pkg::*;
#(
    parameter int DATA_WIDTH        = lp_DATA_WIDTH,
    parameter int BIT_COUNTER_WIDTH = lp_BIT_COUNTER_WIDTH
) (
    input  logic i_clock,
    input  logic i_resetL,
    input  logic i_clear,
    input  logic i_advance,
    output logic o_last
);

    localparam logic [BIT_COUNTER_WIDTH-1:0] last_idx_c = BIT_COUNTER_WIDTH'(DATA_WIDTH - 1);

    logic [BIT_COUNTER_WIDTH-1:0] bit_idx_r;

    // Bit index: cleared outside DATA, increments per sample, wraps after the last bit.
    always_ff @(posedge i_clock) begin
        if (!i_resetL) begin
            bit_idx_r <= '0;
        end else if (i_clear) begin
            bit_idx_r <= '0;
        end else if (i_advance) begin
            if (o_last) begin
                bit_idx_r <= '0;
            end else begin
                bit_idx_r <= bit_idx_r + BIT_COUNTER_WIDTH'(1);
            end
        end else begin
            bit_idx_r <= bit_idx_r;
        end
    end

    // Last-bit comparator.
    always_comb begin
        o_last = (bit_idx_r == last_idx_c);
    end

endmodule

// File: rtl/receiver_frame_sampler.sv
// UART receive framer: synchronises the line, qualifies the start bit at
// mid-bit, shifts in data LSB first, checks the stop bit and strobes the byte.
module receiver_frame_sampler
    import receiver_pkg::*;
#(
    parameter int DATA_WIDTH        = lp_DATA_WIDTH,
    parameter int BIT_COUNTER_WIDTH = lp_BIT_COUNTER_WIDTH,
    parameter int CLKS_PER_BIT      = lp_CLKS_PER_BIT,
    parameter int CLK_COUNTER_WIDTH = lp_CLK_COUNTER_WIDTH
) (
    input  logic                  i_clock,
    input  logic                  i_resetL,
    input  logic                  i_rx,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    output logic                  o_framing_error,
    output logic                  o_busy
);

    localparam logic [CLK_COUNTER_WIDTH-1:0] half_bit_c = CLK_COUNTER_WIDTH'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CLK_COUNTER_WIDTH-1:0] full_bit_c = CLK_COUNTER_WIDTH'(CLKS_PER_BIT - 1);

    logic                         rx_meta_s;
    logic                         rx_s;
    state_t                       state_r;
    logic [CLK_COUNTER_WIDTH-1:0] clk_cnt_r;
    logic [DATA_WIDTH-1:0]        shift_r;
    logic                         sample_s;
    logic                         bit_clear_s;
    logic                         last_bit_s;

    // Two-flop synchroniser; idle-high reset value so reset never looks like a start bit.
    one_cycle_delayer #(.RESET_VALUE(1'b1)) u_sync_0 (
        .i_clock  (i_clock),
        .i_resetL (i_resetL),
        .i_d      (i_rx),
        .o_q      (rx_meta_s)
    );

    one_cycle_delayer #(.RESET_VALUE(1'b1)) u_sync_1 (
        .i_clock  (i_clock),
        .i_resetL (i_resetL),
        .i_d      (rx_meta_s),
        .o_q      (rx_s)
    );

    // Data-bit sample strobe and bit-index clear.
    always_comb begin
        sample_s    = 1'b0;
        bit_clear_s = 1'b1;
        if (state_r == DATA) begin
            sample_s    = (clk_cnt_r == full_bit_c);
            bit_clear_s = 1'b0;
        end else begin
            sample_s    = 1'b0;
            bit_clear_s = 1'b1;
        end
    end

    receiver_bit_counter #(
        .DATA_WIDTH        (DATA_WIDTH),
        .BIT_COUNTER_WIDTH (BIT_COUNTER_WIDTH)
    ) u_bit_counter (
        .i_clock   (i_clock),
        .i_resetL  (i_resetL),
        .i_clear   (bit_clear_s),
        .i_advance (sample_s),
        .o_last    (last_bit_s)
    );

    // Frame FSM with per-bit clock counter, shift register and registered outputs.
    always_ff @(posedge i_clock) begin
        if (!i_resetL) begin
            state_r         <= IDLE;
            clk_cnt_r       <= '0;
            shift_r         <= '0;
            o_data          <= '0;
            o_valid         <= 1'b0;
            o_framing_error <= 1'b0;
            o_busy          <= 1'b0;
        end else begin
            o_valid         <= 1'b0;
            o_framing_error <= 1'b0;
            case (state_r)
                IDLE: begin
                    clk_cnt_r <= '0;
                    if (!rx_s) begin
                        state_r <= START;
                        o_busy  <= 1'b1;
                    end else begin
                        o_busy  <= 1'b0;
                    end
                end
                START: begin
                    if (clk_cnt_r == half_bit_c) begin
                        clk_cnt_r <= '0;
                        if (!rx_s) begin
                            state_r <= DATA;
                        end else begin
                            state_r <= IDLE;
                            o_busy  <= 1'b0;
                        end
                    end else begin
                        clk_cnt_r <= clk_cnt_r + CLK_COUNTER_WIDTH'(1);
                    end
                end
                DATA: begin
                    if (clk_cnt_r == full_bit_c) begin
                        clk_cnt_r <= '0;
                        shift_r   <= {rx_s, shift_r[DATA_WIDTH-1:1]};
                        if (last_bit_s) begin
                            state_r <= STOP;
                        end else begin
                            state_r <= DATA;
                        end
                    end else begin
                        clk_cnt_r <= clk_cnt_r + CLK_COUNTER_WIDTH'(1);
                    end
                end
                STOP: begin
                    if (clk_cnt_r == full_bit_c) begin
                        clk_cnt_r <= '0;
                        if (rx_s) begin
                            o_data  <= shift_r;
                            o_valid <= 1'b1;
                            o_busy  <= 1'b0;
                            state_r <= IDLE;
                        end else begin
                            o_framing_error <= 1'b1;
                            state_r         <= BREAK;
                        end
                    end else begin
                        clk_cnt_r <= clk_cnt_r + CLK_COUNTER_WIDTH'(1);
                    end
                end
                BREAK: begin
                    clk_cnt_r <= '0;
                    if (rx_s) begin
                        state_r <= IDLE;
                        o_busy  <= 1'b0;
                    end else begin
                        state_r <= BREAK;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    clk_cnt_r <= '0;
                    o_busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_receiver_frame_sampler.sv
// Directed bench for receiver_frame_sampler at 16 clocks/bit, 8 data bits.
// Timing reference: i_rx changes just after an edge; that edge is cycle s and
// the frame's o_valid / o_framing_error is visible after edge s+155
// (2 synchroniser cycles, start detect, 8 + 9*16 cycles to the stop sample).
module tb_receiver_frame_sampler;

    localparam int CPB       = 16;
    localparam int FRAME_LAT = 155;

    logic       i_clock;
    logic       i_resetL;
    logic       i_rx;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_framing_error;
    logic       o_busy;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int valid_cnt   = 0;
    int ferr_cnt    = 0;
    int last_valid_cyc = -1;
    int last_ferr_cyc  = -1;
    logic busy_mid;

    receiver_frame_sampler #(
        .DATA_WIDTH        (8),
        .BIT_COUNTER_WIDTH (3),
        .CLKS_PER_BIT      (CPB),
        .CLK_COUNTER_WIDTH (4)
    ) dut (
        .i_clock         (i_clock),
        .i_resetL        (i_resetL),
        .i_rx            (i_rx),
        .o_data          (o_data),
        .o_valid         (o_valid),
        .o_framing_error (o_framing_error),
        .o_busy          (o_busy)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    // Advance one clock, sample outputs 1 time unit after the edge, log strobes.
    task automatic tick();
        @(posedge i_clock);
        #1;
        cyc++;
        if (o_valid === 1'b1) begin
            valid_cnt++;
            last_valid_cyc = cyc;
        end
        if (o_framing_error === 1'b1) begin
            ferr_cnt++;
            last_ferr_cyc = cyc;
        end
        if (o_valid === 1'b1 && o_framing_error === 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL strobe_exclusive: both strobes high at cycle %0d", cyc);
        end
    endtask

    // Drive one full frame: start, 8 data bits LSB first, stop bit.
    task automatic send_frame(input logic [7:0] data, input logic stop_bit);
        for (int b = 0; b < 10; b++) begin
            if (b == 0)      i_rx = 1'b0;
            else if (b == 9) i_rx = stop_bit;
            else             i_rx = data[b-1];
            repeat (CPB) tick();
            if (b == 5) busy_mid = o_busy;
        end
    endtask

    task automatic test_reset();
        i_resetL = 1'b0;
        i_rx     = 1'b1;
        repeat (3) tick();
        vectors++; if (o_data !== 8'h00) begin miscompares++; $display("FAIL reset_data: got %h want 00", o_data); end
        vectors++; if (o_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", o_valid); end
        vectors++; if (o_framing_error !== 1'b0) begin miscompares++; $display("FAIL reset_ferr: got %b want 0", o_framing_error); end
        vectors++; if (o_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", o_busy); end
        i_resetL = 1'b1;
    endtask

    task automatic test_idle_line();
        int bad = 0;
        i_rx = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (o_busy !== 1'b0 || o_valid !== 1'b0 || o_framing_error !== 1'b0) bad++;
        end
        vectors++; if (bad !== 0) begin miscompares++; $display("FAIL idle_quiet: %0d active cycles, want 0", bad); end
        vectors++; if (o_data !== 8'h00) begin miscompares++; $display("FAIL idle_data: got %h want 00", o_data); end
    endtask

    task automatic test_frame_a5();
        int s  = cyc;
        int v0 = valid_cnt;
        int f0 = ferr_cnt;
        send_frame(8'hA5, 1'b1);
        repeat (20) tick();
        vectors++; if (valid_cnt - v0 !== 1) begin miscompares++; $display("FAIL a5_valid_count: got %0d want 1", valid_cnt - v0); end
        vectors++; if (last_valid_cyc !== s + FRAME_LAT) begin miscompares++; $display("FAIL a5_valid_time: got %0d want %0d", last_valid_cyc - s, FRAME_LAT); end
        vectors++; if (o_data !== 8'hA5) begin miscompares++; $display("FAIL a5_data: got %h want a5", o_data); end
        vectors++; if (ferr_cnt !== f0) begin miscompares++; $display("FAIL a5_no_ferr: got %0d want %0d", ferr_cnt, f0); end
        vectors++; if (busy_mid !== 1'b1) begin miscompares++; $display("FAIL a5_busy_mid: got %b want 1", busy_mid); end
        vectors++; if (o_busy !== 1'b0) begin miscompares++; $display("FAIL a5_busy_after: got %b want 0", o_busy); end
    endtask

    task automatic test_glitch();
        int s  = cyc;
        int v0 = valid_cnt;
        int f0 = ferr_cnt;
        i_rx = 1'b0;
        repeat (4) tick();
        i_rx = 1'b1;
        tick();
        vectors++; if (o_busy !== 1'b1) begin miscompares++; $display("FAIL glitch_busy_start: got %b want 1", o_busy); end
        while (cyc < s + 12) tick();
        vectors++; if (o_busy !== 1'b0) begin miscompares++; $display("FAIL glitch_abort: busy %b want 0", o_busy); end
        repeat (200) tick();
        vectors++; if (valid_cnt !== v0 || ferr_cnt !== f0) begin miscompares++; $display("FAIL glitch_no_strobe: valid %0d ferr %0d want 0 0", valid_cnt - v0, ferr_cnt - f0); end
        vectors++; if (o_data !== 8'hA5) begin miscompares++; $display("FAIL glitch_data: got %h want a5", o_data); end
    endtask

    task automatic test_framing_break();
        int s  = cyc;
        int v0 = valid_cnt;
        int f0 = ferr_cnt;
        send_frame(8'h3C, 1'b0);
        i_rx = 1'b0;
        repeat (40) tick();
        vectors++; if (ferr_cnt - f0 !== 1) begin miscompares++; $display("FAIL ferr_count: got %0d want 1", ferr_cnt - f0); end
        vectors++; if (last_ferr_cyc !== s + FRAME_LAT) begin miscompares++; $display("FAIL ferr_time: got %0d want %0d", last_ferr_cyc - s, FRAME_LAT); end
        vectors++; if (o_busy !== 1'b1) begin miscompares++; $display("FAIL break_busy: got %b want 1", o_busy); end
        vectors++; if (o_data !== 8'hA5) begin miscompares++; $display("FAIL ferr_data_kept: got %h want a5", o_data); end
        i_rx = 1'b1;
        repeat (4) tick();
        vectors++; if (o_busy !== 1'b0) begin miscompares++; $display("FAIL break_exit: busy %b want 0", o_busy); end
        repeat (200) tick();
        vectors++; if (valid_cnt !== v0 || ferr_cnt - f0 !== 1) begin miscompares++; $display("FAIL break_spurious: valid %0d ferr %0d want 0 1", valid_cnt - v0, ferr_cnt - f0); end
    endtask

    task automatic test_back_to_back();
        int s  = cyc;
        int v0 = valid_cnt;
        int first;
        send_frame(8'h00, 1'b1);
        first = last_valid_cyc;
        vectors++; if (first !== s + FRAME_LAT) begin miscompares++; $display("FAIL b2b_first_time: got %0d want %0d", first - s, FRAME_LAT); end
        vectors++; if (o_data !== 8'h00) begin miscompares++; $display("FAIL b2b_first_data: got %h want 00", o_data); end
        send_frame(8'hFF, 1'b1);
        repeat (20) tick();
        vectors++; if (last_valid_cyc - first !== 10 * CPB) begin miscompares++; $display("FAIL b2b_spacing: got %0d want %0d", last_valid_cyc - first, 10 * CPB); end
        vectors++; if (o_data !== 8'hFF) begin miscompares++; $display("FAIL b2b_second_data: got %h want ff", o_data); end
        vectors++; if (valid_cnt - v0 !== 2) begin miscompares++; $display("FAIL b2b_count: got %0d want 2", valid_cnt - v0); end
    endtask

    task automatic test_reset_midframe();
        int v0 = valid_cnt;
        int f0 = ferr_cnt;
        int s;
        logic [7:0] aborted;
        aborted = 8'h81;
        i_rx = 1'b0;
        repeat (CPB) tick();
        for (int b = 0; b < 3; b++) begin
            i_rx = aborted[b];
            repeat (CPB) tick();
        end
        i_rx = aborted[3];
        repeat (CPB / 2) tick();
        i_resetL = 1'b0;
        i_rx     = 1'b1;
        repeat (2) tick();
        vectors++; if (o_data !== 8'h00) begin miscompares++; $display("FAIL rst_mid_data: got %h want 00", o_data); end
        vectors++; if (o_busy !== 1'b0 || o_valid !== 1'b0 || o_framing_error !== 1'b0) begin miscompares++; $display("FAIL rst_mid_flags: busy %b valid %b ferr %b want 0 0 0", o_busy, o_valid, o_framing_error); end
        i_resetL = 1'b1;
        repeat (200) tick();
        vectors++; if (valid_cnt !== v0 || ferr_cnt !== f0) begin miscompares++; $display("FAIL rst_mid_no_strobe: valid %0d ferr %0d want 0 0", valid_cnt - v0, ferr_cnt - f0); end
        s = cyc;
        send_frame(8'h42, 1'b1);
        repeat (20) tick();
        vectors++; if (o_data !== 8'h42) begin miscompares++; $display("FAIL rst_mid_next_data: got %h want 42", o_data); end
        vectors++; if (valid_cnt - v0 !== 1 || last_valid_cyc !== s + FRAME_LAT) begin miscompares++; $display("FAIL rst_mid_next_valid: count %0d at %0d want 1 at %0d", valid_cnt - v0, last_valid_cyc - s, FRAME_LAT); end
    endtask

    initial begin
        i_resetL = 1'b0;
        i_rx     = 1'b1;
        busy_mid = 1'b0;
        test_reset();
        test_idle_line();
        test_frame_a5();
        test_glitch();
        test_framing_break();
        test_back_to_back();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/receiver_frame_sampler.md
Name: receiver_frame_sampler

Overview:
UART receive-side counterpart to the transmitter bit counter and control unit. Synchronises the serial line and detects the start bit. Samples each bit at mid-bit using an internal per-bit clock counter, shifts in DATA_WIDTH data bits LSB first and checks the stop bit. Presents a parallel byte with a one-cycle valid strobe to the receiver datapath.

Parameters:
DATA_WIDTH, 8, data bits per frame
BIT_COUNTER_WIDTH, 3, width of data-bit index; must satisfy 2^BIT_COUNTER_WIDTH >= DATA_WIDTH
CLKS_PER_BIT, 16, i_clock cycles per bit period; even, >= 4
CLK_COUNTER_WIDTH, 4, width of per-bit clock counter; must hold CLKS_PER_BIT-1

Ports:
i_clock  input  1  single system clock, rising edge
i_resetL  input  1  synchronous active-low reset
i_rx  input  1  asynchronous serial line, idle high
o_data  output  DATA_WIDTH  last correctly framed byte
o_valid  output  1  one-cycle strobe: o_data updated this cycle
o_framing_error  output  1  one-cycle strobe: stop bit sampled low
o_busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (i_resetL low at a rising edge):
  - state = IDLE; counters = 0; shift register = 0.
  - o_data = 0, o_valid = 0, o_framing_error = 0, o_busy = 0.
  - Both synchroniser flops = 1.
  - Reset takes priority over every other event, including mid-frame; no strobe is emitted for a frame cut by reset.
- Synchroniser: two-flop on i_rx; the FSM sees only the second-flop output rx_s. Fixed latency of 2 cycles.
- All outputs are registered.
- States: IDLE, START, DATA, STOP, BREAK.
- IDLE:
  - Clock counter held at 0.
  - rx_s == 0 -> START. Call this cycle t0.
- START:
  - Clock counter counts up.
  - When it reaches CLKS_PER_BIT/2-1, sample rx_s (cycle t0+CLKS_PER_BIT/2):
    - rx_s == 0 -> DATA, with clock counter and bit index cleared.
    - rx_s == 1 -> IDLE (glitch rejected, no strobe).
- DATA:
  - Clock counter wraps at CLKS_PER_BIT-1; each wrap is a sample point.
  - At each sample point: shift right, rx_s into MSB, increment bit index.
  - Sample point with bit index == DATA_WIDTH-1 -> STOP; bit index wraps to 0.
  - Data bit k is sampled at t0 + CLKS_PER_BIT/2 + (k+1)*CLKS_PER_BIT.
- STOP:
  - Sample at the next clock-counter wrap, cycle ts = t0 + CLKS_PER_BIT/2 + (DATA_WIDTH+1)*CLKS_PER_BIT.
  - rx_s == 1:
    - o_data <= shift register, o_valid = 1 in cycle ts+1.
    - -> IDLE, so a new start bit can be accepted from cycle ts+1 (back-to-back frames, no extra idle required).
  - rx_s == 0:
    - o_framing_error = 1 in cycle ts+1; o_data unchanged.
    - -> BREAK.
- BREAK: stays until rx_s == 1, then -> IDLE. Prevents a break condition being read as a new start bit.
- o_valid and o_framing_error:
  - Never asserted together.
  - Each is high for exactly one cycle per frame.
- o_data holds its value until the next valid frame.
- A line change during DATA that is not at a sample point has no effect.

Decomposition:
- Shared package receiver_pkg:
  - state encoding localparams (IDLE=0, START=1, DATA=2, STOP=3, BREAK=4, 3 bits);
  - lp_HALF_BIT = CLKS_PER_BIT/2-1;
  - lp_FULL_BIT = CLKS_PER_BIT-1;
  - lp_DATA_WIDTH_minus_one.
- One natural sub-module: receiver_bit_counter. It contains the bit-index register, its incrementer and the equal-MSB comparator; it is cleared when the FSM is not in DATA and advanced by the sample-point strobe.
- The two-flop synchroniser reuses the existing one_cycle_delayer chained twice.

Test Plan:
- CLKS_PER_BIT=16, DATA_WIDTH=8, frame 0xA5 (LSB first 1,0,1,0,0,1,0,1), stop=1, idle high -> o_valid high for exactly one cycle at t0+153, o_data=0xA5, o_framing_error=0, o_busy low from t0+153.
- i_rx low for 4 cycles, then high -> START aborts at t0+8, returns to IDLE, no o_valid, no o_framing_error, o_data unchanged.
- Frame 0x3C with stop bit = 0, line then held low 40 cycles, then high -> o_framing_error one cycle at t0+153, no o_valid, FSM in BREAK until rx_s is high, then IDLE; no spurious frame.
- Back-to-back 0x00 then 0xFF with the second start bit directly after the stop bit -> two o_valid strobes exactly 160 cycles apart, o_data=0x00 then 0xFF.
- Reset asserted during data bit 3 of frame 0x81, released, then frame 0x42 sent -> all outputs 0 after reset, no strobe for the aborted frame, then o_valid with o_data=0x42.
- Line held high 1000 cycles after reset -> o_busy, o_valid and o_framing_error stay 0; o_data=0.
